// File: rtl/alu_2bit_checker.sv
// Response checker for the 2-bit ALU: golden compare, pass/fail/skip counters, first-failure capture.
// Optional build macro ALU_CHK_HALT_ON_FAIL_EN: the first recorded failure also ends the run.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset, waiting for start; vectors ignored
// ST_RUN  | sampling vectors on in_valid, counting and capturing
// ST_DONE | run ended by stop (or first failure when halting); vectors ignored
module alu_2bit_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    input  logic [2:0]       in_sel,
    input  logic [1:0]       dut_result,
    input  logic             dut_carry,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             err_valid,
    output logic [1:0]       err_a,
    output logic [1:0]       err_b,
    output logic [2:0]       err_sel,
    output logic [1:0]       err_result,
    output logic             err_carry,
    output logic [1:0]       exp_result,
    output logic             exp_carry
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic             err_valid_q, err_valid_d;
    logic [1:0]       err_a_q, err_a_d;
    logic [1:0]       err_b_q, err_b_d;
    logic [2:0]       err_sel_q, err_sel_d;
    logic [1:0]       err_result_q, err_result_d;
    logic             err_carry_q, err_carry_d;
    logic [1:0]       exp_result_q, exp_result_d;
    logic             exp_carry_q, exp_carry_d;

    logic [2:0] gold_wide;
    logic [1:0] gold_result;
    logic       gold_carry;
    logic       gold_legal;
    logic       accept;
    logic       match;

    // Golden 2-bit model; SUB borrow falls out of the 3-bit wrap.
    always_comb begin
        gold_wide  = 3'd0;
        gold_legal = 1'b1;
        case (in_sel)
            3'b000:  gold_wide = {1'b0, in_a} + {1'b0, in_b};
            3'b001:  gold_wide = {1'b0, in_a} - {1'b0, in_b};
            3'b010:  gold_wide = {1'b0, in_a & in_b};
            3'b011:  gold_wide = {1'b0, in_a | in_b};
            3'b100:  gold_wide = {1'b0, in_a ^ in_b};
            default: gold_legal = 1'b0;
        endcase
        gold_result = gold_wide[1:0];
        gold_carry  = gold_wide[2];
    end

    assign accept = (state_q == ST_RUN) && in_valid && !start;
    assign match  = (dut_result == gold_result) && (dut_carry == gold_carry);

    always_comb begin
        state_d      = state_q;
        mismatch_d   = 1'b0;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        err_valid_d  = err_valid_q;
        err_a_d      = err_a_q;
        err_b_d      = err_b_q;
        err_sel_d    = err_sel_q;
        err_result_d = err_result_q;
        err_carry_d  = err_carry_q;
        exp_result_d = exp_result_q;
        exp_carry_d  = exp_carry_q;

        if (start) begin
            state_d      = ST_RUN;
            pass_cnt_d   = '0;
            fail_cnt_d   = '0;
            skip_cnt_d   = '0;
            err_valid_d  = 1'b0;
            err_a_d      = 2'd0;
            err_b_d      = 2'd0;
            err_sel_d    = 3'd0;
            err_result_d = 2'd0;
            err_carry_d  = 1'b0;
            exp_result_d = 2'd0;
            exp_carry_d  = 1'b0;
        end else begin
            if (accept) begin
                if (!gold_legal) begin
                    if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + CNT_ONE;
                end else if (match) begin
                    if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_ONE;
                end else begin
                    mismatch_d = 1'b1;
                    if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_ONE;
                    if (!err_valid_q) begin
                        err_valid_d  = 1'b1;
                        err_a_d      = in_a;
                        err_b_d      = in_b;
                        err_sel_d    = in_sel;
                        err_result_d = dut_result;
                        err_carry_d  = dut_carry;
                        exp_result_d = gold_result;
                        exp_carry_d  = gold_carry;
`ifdef ALU_CHK_HALT_ON_FAIL_EN
                        state_d      = ST_DONE;
`endif
                    end
                end
            end
            if ((state_q == ST_RUN) && stop) state_d = ST_DONE;
        end
    end

    // busy/done are registered copies of the next state so they move on the consuming edge.
    assign busy_d = (state_d == ST_RUN);
    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            skip_cnt_q   <= '0;
            err_valid_q  <= 1'b0;
            err_a_q      <= 2'd0;
            err_b_q      <= 2'd0;
            err_sel_q    <= 3'd0;
            err_result_q <= 2'd0;
            err_carry_q  <= 1'b0;
            exp_result_q <= 2'd0;
            exp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mismatch_q   <= mismatch_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
            err_valid_q  <= err_valid_d;
            err_a_q      <= err_a_d;
            err_b_q      <= err_b_d;
            err_sel_q    <= err_sel_d;
            err_result_q <= err_result_d;
            err_carry_q  <= err_carry_d;
            exp_result_q <= exp_result_d;
            exp_carry_q  <= exp_carry_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mismatch   = mismatch_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign skip_cnt   = skip_cnt_q;
    assign err_valid  = err_valid_q;
    assign err_a      = err_a_q;
    assign err_b      = err_b_q;
    assign err_sel    = err_sel_q;
    assign err_result = err_result_q;
    assign err_carry  = err_carry_q;
    assign exp_result = exp_result_q;
    assign exp_carry  = exp_carry_q;

endmodule

// File: tb/tb_alu_2bit_checker.sv
// Bench for alu_2bit_checker: vector table plus random run, expected outputs queued per cycle.
module tb_alu_2bit_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, stop, in_valid, dut_carry;
    logic [1:0] in_a, in_b, dut_result;
    logic [2:0] in_sel;
    logic       busy, done, mismatch, err_valid, err_carry, exp_carry;
    logic [7:0] pass_cnt, fail_cnt, skip_cnt;
    logic [1:0] err_a, err_b, err_result, exp_result;
    logic [2:0] err_sel;
    logic       busy2, done2, mis2, ev2, ec2, xc2;
    logic [1:0] pass2, fail2, skip2, ea2, eb2, er2, xr2;
    logic [2:0] es2;

    alu_2bit_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .dut_result(dut_result), .dut_carry(dut_carry),
        .busy(busy), .done(done), .mismatch(mismatch), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .skip_cnt(skip_cnt), .err_valid(err_valid), .err_a(err_a), .err_b(err_b), .err_sel(err_sel),
        .err_result(err_result), .err_carry(err_carry), .exp_result(exp_result), .exp_carry(exp_carry));

    alu_2bit_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .dut_result(dut_result), .dut_carry(dut_carry),
        .busy(busy2), .done(done2), .mismatch(mis2), .pass_cnt(pass2), .fail_cnt(fail2),
        .skip_cnt(skip2), .err_valid(ev2), .err_a(ea2), .err_b(eb2), .err_sel(es2),
        .err_result(er2), .err_carry(ec2), .exp_result(xr2), .exp_carry(xc2));

    typedef struct {
        logic       rn, st, sp, v;
        logic [1:0] a, b;
        logic [2:0] sel;
        logic [1:0] r;
        logic       c;
        logic       lg;
        logic [1:0] gr;
        logic       gc;
    } vec_t;

    typedef struct {
        logic       busy, done, mis, ev;
        int         pass, fail, skip, pass2;
        logic [1:0] ea, eb, er, xr;
        logic [2:0] es;
        logic       ec, xc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // bench model state: 0 idle, 1 run, 2 done
    int   m_state;
    exp_t m;

    function automatic vec_t mk(logic rn, logic st, logic sp, logic v, logic [1:0] a, logic [1:0] b,
                                logic [2:0] sel, logic [1:0] r, logic c, logic lg, logic [1:0] gr, logic gc);
        vec_t t;
        t.rn = rn; t.st = st; t.sp = sp; t.v = v; t.a = a; t.b = b; t.sel = sel;
        t.r = r; t.c = c; t.lg = lg; t.gr = gr; t.gc = gc;
        return t;
    endfunction

    function automatic logic [3:0] ref_alu(logic [1:0] a, logic [1:0] b, logic [2:0] sel);
        int x;
        x = 0;
        case (sel)
            3'd0: x = int'(a) + int'(b);
            3'd1: x = (int'(a) < int'(b)) ? (int'(a) - int'(b) + 4 + 4) : (int'(a) - int'(b));
            3'd2: x = int'(a & b);
            3'd3: x = int'(a | b);
            3'd4: x = int'(a ^ b);
            default: return 4'b0000;
        endcase
        return {1'b1, x[2], x[1:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m = '{busy: 1'b0, done: 1'b0, mis: 1'b0, ev: 1'b0, pass: 0, fail: 0, skip: 0, pass2: 0,
              ea: 2'd0, eb: 2'd0, er: 2'd0, xr: 2'd0, es: 3'd0, ec: 1'b0, xc: 1'b0};
    endtask

    task automatic step(vec_t t);
        exp_t e;
        rst_n = t.rn; start = t.st; stop = t.sp; in_valid = t.v;
        in_a = t.a; in_b = t.b; in_sel = t.sel; dut_result = t.r; dut_carry = t.c;
        if (!t.rn) begin
            model_reset();
        end else if (t.st) begin
            model_reset();
            m_state = 1;
        end else begin
            int prev;
            prev  = m_state;
            m.mis = 1'b0;
            if (prev == 1 && t.v) begin
                if (!t.lg) begin
                    if (m.skip < 255) m.skip++;
                end else if (t.r == t.gr && t.c == t.gc) begin
                    if (m.pass < 255) m.pass++;
                    if (m.pass2 < 3) m.pass2++;
                end else begin
                    m.mis = 1'b1;
                    if (m.fail < 255) m.fail++;
                    if (!m.ev) begin
                        m.ev = 1'b1; m.ea = t.a; m.eb = t.b; m.es = t.sel;
                        m.er = t.r; m.ec = t.c; m.xr = t.gr; m.xc = t.gc;
`ifdef ALU_CHK_HALT_ON_FAIL_EN
                        m_state = 2;
`endif
                    end
                end
            end
            if (prev == 1 && t.sp) m_state = 2;
        end
        m.busy = (m_state == 1);
        m.done = (m_state == 2);
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("mismatch", 32'(mismatch), 32'(e.mis));
        chk("pass_cnt", 32'(pass_cnt), e.pass);
        chk("fail_cnt", 32'(fail_cnt), e.fail);
        chk("skip_cnt", 32'(skip_cnt), e.skip);
        chk("pass_cnt_w2", 32'(pass2), e.pass2);
        chk("err_valid", 32'(err_valid), 32'(e.ev));
        chk("err_a", 32'(err_a), 32'(e.ea));
        chk("err_b", 32'(err_b), 32'(e.eb));
        chk("err_sel", 32'(err_sel), 32'(e.es));
        chk("err_result", 32'(err_result), 32'(e.er));
        chk("err_carry", 32'(err_carry), 32'(e.ec));
        chk("exp_result", 32'(exp_result), 32'(e.xr));
        chk("exp_carry", 32'(exp_carry), 32'(e.xc));
    endtask

    initial begin
        logic [3:0] g;
        vec_t       t;
        model_reset();
        // rn st sp v  a     b     sel     r     c   lg  gr    gc
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2'b01, 2'b10, 3'b000, 2'b11, 0, 1, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b000, 2'b00, 0, 1, 2'b11, 0)); // idle: ignored
        tbl.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0)); // stop in idle
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b000, 2'b11, 0, 1, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b001, 2'b11, 1, 1, 2'b11, 1));
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b010, 2'b00, 0, 1, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b011, 2'b11, 0, 1, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b100, 2'b11, 0, 1, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b11, 2'b01, 3'b000, 2'b00, 1, 1, 2'b00, 1));
        tbl.push_back(mk(1, 0, 0, 1, 2'b11, 2'b01, 3'b001, 2'b11, 0, 1, 2'b10, 0)); // first failure
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b11, 3'b010, 2'b01, 1, 1, 2'b10, 0)); // second failure
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b01, 3'b101, 2'b10, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b01, 3'b110, 2'b11, 1, 0, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b11, 2'b11, 3'b111, 2'b00, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0)); // stop
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b000, 2'b11, 0, 1, 2'b11, 0)); // done: ignored
        tbl.push_back(mk(1, 0, 1, 1, 2'b11, 2'b01, 3'b001, 2'b00, 0, 1, 2'b10, 0)); // stop in done
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0)); // restart from done
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b01, 3'b000, 2'b11, 0, 1, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b01, 3'b011, 2'b11, 0, 1, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b01, 3'b100, 2'b11, 0, 1, 2'b11, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b01, 3'b010, 2'b00, 0, 1, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b01, 3'b001, 2'b01, 0, 1, 2'b01, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b11, 2'b11, 3'b000, 2'b10, 1, 1, 2'b10, 1)); // 6th pass, w2 holds 3
        tbl.push_back(mk(1, 1, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0)); // start+stop
        tbl.push_back(mk(1, 0, 0, 1, 2'b00, 2'b01, 3'b011, 2'b01, 0, 1, 2'b01, 0));
        tbl.push_back(mk(1, 1, 0, 1, 2'b01, 2'b01, 3'b000, 2'b10, 0, 1, 2'b10, 0)); // start+valid
        tbl.push_back(mk(1, 0, 1, 1, 2'b00, 2'b00, 3'b100, 2'b00, 0, 1, 2'b00, 0)); // stop+valid counted
        tbl.push_back(mk(1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0));
        tbl.push_back(mk(1, 0, 0, 1, 2'b00, 2'b11, 3'b001, 2'b11, 0, 1, 2'b01, 1)); // fail
        tbl.push_back(mk(1, 0, 0, 1, 2'b10, 2'b10, 3'b000, 2'b00, 1, 1, 2'b00, 1));
        tbl.push_back(mk(0, 1, 1, 1, 2'b10, 2'b10, 3'b000, 2'b00, 1, 1, 2'b00, 1)); // reset mid-run
        tbl.push_back(mk(1, 0, 0, 1, 2'b01, 2'b10, 3'b000, 2'b11, 0, 1, 2'b11, 0));

        foreach (tbl[i]) step(tbl[i]);

        // random run through the reference function, with some corrupted responses
        step(mk(1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0));
        for (int i = 0; i < 40; i++) begin
            t = mk(1, 0, 0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00, 0, 1, 2'b00, 0);
            g = ref_alu(t.a, t.b, t.sel);
            t.lg = g[3]; t.gc = g[2]; t.gr = g[1:0];
            t.r = t.gr; t.c = t.gc;
            if ($urandom_range(0, 5) == 0) t.r = t.r ^ 2'($urandom_range(1, 3));
            else if ($urandom_range(0, 7) == 0) t.c = ~t.c;
            step(t);
        end
        step(mk(1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, 2'b00, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
